// File: rtl/move_collector.sv
// Sequencer for the square move-generation array: clear, wait for done, then drain every
// square FIFO in index order and stream the valid 19-bit moves out over valid/ready.
module move_collector #(
    parameter int NSQ     = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   sq_reset,
    input  logic [NSQ-1:0]         sq_done,
    input  logic [NSQ-1:0]         sq_empty,
    output logic [$clog2(NSQ)-1:0] sq_sel,
    input  logic [159:0]           sq_q,
    output logic [NSQ-1:0]         sq_rden,
    output logic [18:0]            mv_data,
    output logic                   mv_valid,
    input  logic                   mv_ready,
    output logic                   busy,
    output logic                   list_done,
    output logic                   err,
    output logic [7:0]             move_count
);
    localparam int IW = $clog2(NSQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NSQ - 1);
    localparam logic [WW-1:0]  WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [NSQ-1:0] ONE_HOT0 = NSQ'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WAIT, S_SETTLE, S_SCAN, S_READ, S_LAT, S_UNPK, S_FIN, S_ERR
    } state_t;

    state_t         r_state, w_next;
    logic [IW-1:0]  r_idx;
    logic [WW-1:0]  r_wd;
    logic [151:0]   r_word, w_word_nxt;
    logic [2:0]     r_slot, w_slot_nxt;
    logic [18:0]    w_cur, w_mv;
    logic           w_adv, w_hs, w_mv_ok;
    logic           r_sq_reset, r_mv_valid, r_busy, r_list_done, r_err;
    logic [NSQ-1:0] r_sq_rden;
    logic [18:0]    r_mv_data;
    logic [7:0]     r_move_count;
    logic           w_unused_hi;

    function automatic logic [18:0] slot_of(input logic [151:0] word, input logic [2:0] slot);
        logic [18:0] m;
        m = '0;
        for (int k = 0; k < 8; k++)
            if (slot == 3'(k)) m = word[19*k +: 19];
        return m;
    endfunction

    // Word bits [159:152] carry no move data.
    assign w_unused_hi = ^sq_q[159:152];

    always_comb begin
        w_next     = r_state;
        w_word_nxt = r_word;
        w_slot_nxt = r_slot;
        w_cur      = slot_of(r_word, r_slot);
        w_hs       = (r_state == S_UNPK) && !w_cur[18] && mv_ready;
        w_adv      = (r_state == S_UNPK) && (w_cur[18] || mv_ready);
        case (r_state)
            S_IDLE:   if (start) w_next = S_CLR;
            S_CLR:    w_next = S_WAIT;
            S_WAIT: begin
                if (&sq_done)              w_next = S_SETTLE;
                else if (r_wd == WD_LAST)  w_next = S_ERR;
            end
            S_SETTLE: if (r_wd == WW'(1)) w_next = S_SCAN;
            S_SCAN: begin
                if (!sq_empty[r_idx])       w_next = S_READ;
                else if (r_idx == LAST_IDX) w_next = S_FIN;
            end
            S_READ:   w_next = S_LAT;
            S_LAT: begin
                w_word_nxt = sq_q[151:0];
                w_slot_nxt = 3'd7;
                w_next     = S_UNPK;
            end
            S_UNPK: begin
                // Return to SCAN on the same square: its FIFO may hold further words.
                if (w_adv) begin
                    if (r_slot == 3'd0) w_next = S_SCAN;
                    else                w_slot_nxt = r_slot - 3'd1;
                end
            end
            S_FIN:    w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        // Stream outputs are registered, so they are computed from the next slot.
        w_mv    = slot_of(w_word_nxt, w_slot_nxt);
        w_mv_ok = (w_next == S_UNPK) && !w_mv[18];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_wd         <= '0;
            r_sq_reset   <= 1'b1;
            r_sq_rden    <= '0;
            r_mv_valid   <= 1'b0;
            r_mv_data    <= '0;
            r_busy       <= 1'b0;
            r_list_done  <= 1'b0;
            r_err        <= 1'b0;
            r_move_count <= '0;
        end else begin
            r_state <= w_next;
            // Shared cycle counter: watchdog in WAIT, settle delay in SETTLE.
            if (w_next != r_state)
                r_wd <= '0;
            else if (r_state == S_WAIT || r_state == S_SETTLE)
                r_wd <= r_wd + 1'b1;
            if (r_state == S_SETTLE)
                r_idx <= '0;
            else if (r_state == S_SCAN && w_next == S_SCAN)
                r_idx <= r_idx + 1'b1;
            r_sq_reset  <= (w_next == S_CLR);
            r_sq_rden   <= (w_next == S_READ) ? (ONE_HOT0 << r_idx) : '0;
            r_mv_valid  <= w_mv_ok;
            r_mv_data   <= w_mv_ok ? w_mv : '0;
            r_busy      <= (w_next != S_IDLE);
            r_list_done <= (w_next == S_FIN) || (w_next == S_ERR);
            if (w_next == S_CLR)
                r_err <= 1'b0;
            else if (w_next == S_ERR)
                r_err <= 1'b1;
            if (w_next == S_CLR)
                r_move_count <= '0;
            else if (w_hs && r_move_count != 8'hFF)
                r_move_count <= r_move_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        r_word <= w_word_nxt;
        r_slot <= w_slot_nxt;
    end

    assign sq_reset   = r_sq_reset;
    assign sq_sel     = r_idx;
    assign sq_rden    = r_sq_rden;
    assign mv_data    = r_mv_data;
    assign mv_valid   = r_mv_valid;
    assign busy       = r_busy;
    assign list_done  = r_list_done;
    assign err        = r_err;
    assign move_count = r_move_count;
endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: models the square array FIFOs and checks the move stream
// against a list derived directly from the loaded FIFO words.
module tb_move_collector;
    localparam int NSQ = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           mv_ready = 1'b0;
    logic [63:0]    sq_done = '0;
    logic [63:0]    sq_empty = '1;
    logic [159:0]   sq_q = '0;
    logic           sq_reset;
    logic [5:0]     sq_sel;
    logic [63:0]    sq_rden;
    logic [18:0]    mv_data;
    logic           mv_valid, busy, list_done, err;
    logic [7:0]     move_count;

    move_collector #(.NSQ(64), .TIMEOUT(256)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sq_reset(sq_reset),
        .sq_done(sq_done), .sq_empty(sq_empty), .sq_sel(sq_sel), .sq_q(sq_q),
        .sq_rden(sq_rden), .mv_data(mv_data), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .busy(busy), .list_done(list_done), .err(err), .move_count(move_count)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [159:0] fifo [NSQ][$];
    logic [159:0] pend [NSQ][$];
    logic [63:0]  done_mask = '1;
    int           done_delay = 5;
    int           cd = 0;
    bit           armed = 0;
    int           rden_cnt [NSQ];
    logic [18:0]  exp_q [$];
    int           rdy_mode = 0;
    int           ld_count = 0;
    bit           prev_stall = 0;
    logic [18:0]  prev_data = '0;

    // Square array model: sclr on sq_reset, loads its words and raises done after a delay.
    always @(posedge clk) begin
        logic [63:0] e;
        if (sq_rden != '0) begin
            n_chk++;
            if ($countones(sq_rden) != 1 || sq_rden[sq_sel] !== 1'b1) begin
                n_err++;
                $display("FAIL rden_onehot: got rden=%h sel=%0d, required one-hot at sel", sq_rden, sq_sel);
            end
            for (int i = 0; i < NSQ; i++) begin
                if (sq_rden[i]) begin
                    n_chk++;
                    if (fifo[i].size() == 0) begin
                        n_err++;
                        $display("FAIL rden_empty: square %0d got read strobe, required none while empty", i);
                    end else begin
                        sq_q <= fifo[i].pop_front();
                        rden_cnt[i]++;
                    end
                end
            end
        end
        if (sq_reset) begin
            for (int i = 0; i < NSQ; i++) fifo[i].delete();
            sq_done <= '0;
            cd = done_delay;
            armed = 1;
        end else if (armed) begin
            if (cd == 0) begin
                for (int i = 0; i < NSQ; i++)
                    for (int j = 0; j < pend[i].size(); j++) fifo[i].push_back(pend[i][j]);
                sq_done <= done_mask;
                armed = 0;
            end else begin
                cd--;
            end
        end
        for (int i = 0; i < NSQ; i++) e[i] = (fifo[i].size() == 0);
        sq_empty <= e;
    end

    // Stream consumer: drives mv_ready, checks order and stability while stalled.
    always @(negedge clk) begin
        logic [18:0] e;
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            case (rdy_mode)
                0:       mv_ready = 1'b1;
                1:       mv_ready = ~mv_ready;
                2:       mv_ready = 1'($urandom_range(0, 1));
                default: mv_ready = 1'b0;
            endcase
            if (prev_stall) begin
                n_chk++;
                if (mv_valid !== 1'b1 || mv_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_stable: got valid=%b data=%h, required valid=1 data=%h", mv_valid, mv_data, prev_data);
                end
            end
            if (mv_valid && mv_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL move_extra: got %h, required no move", mv_data);
                end else begin
                    e = exp_q.pop_front();
                    if (mv_data !== e) begin
                        n_err++;
                        $display("FAIL move_data: got %h, required %h", mv_data, e);
                    end
                end
            end
            if (list_done) ld_count++;
            prev_stall = mv_valid && !mv_ready;
            prev_data  = mv_data;
        end
    end

    function automatic logic [159:0] mkword(input logic [7:0] vmask);
        logic [159:0] w;
        logic [18:0]  s;
        w = '0;
        w[159:152] = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            s = 19'($urandom);
            s[18] = ~vmask[k];
            w[19*k +: 19] = s;
        end
        return w;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < NSQ; i++) pend[i].delete();
        exp_q.delete();
        done_mask  = '1;
        done_delay = 5;
    endtask

    // Expected stream: squares ascending, words in FIFO order, slots 7..0, valid slots only.
    task automatic build_exp();
        logic [159:0] w;
        logic [18:0]  m;
        exp_q.delete();
        for (int s = 0; s < NSQ; s++)
            for (int j = 0; j < pend[s].size(); j++) begin
                w = pend[s][j];
                for (int k = 7; k >= 0; k--) begin
                    m = w[19*k +: 19];
                    if (!m[18]) exp_q.push_back(m);
                end
            end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_pass(input string name, input int exp_lat);
        int  n, t_done, exp_n, exp_c, ld0;
        bit  seen0, got;
        build_exp();
        exp_n = exp_q.size();
        exp_c = (exp_n > 255) ? 255 : exp_n;
        ld0 = ld_count;
        do_start();
        n_chk++;
        if (sq_reset !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || move_count !== 8'd0) begin
            n_err++;
            $display("FAIL %s_clr: got sq_reset=%b busy=%b err=%b cnt=%0d, required 1 1 0 0", name, sq_reset, busy, err, move_count);
        end
        t_done = -1; seen0 = 0; got = 0;
        for (n = 1; n <= 6000; n++) begin
            @(negedge clk);
            if (!(&sq_done)) seen0 = 1;
            else if (seen0 && t_done < 0) t_done = n;
            if (list_done) begin got = 1; break; end
        end
        n_chk++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_timeout: got no list_done, required one within 6000 cycles", name);
        end else begin
            n_chk++;
            if (move_count !== 8'(exp_c) || busy !== 1'b1 || err !== 1'b0) begin
                n_err++;
                $display("FAIL %s_end: got cnt=%0d busy=%b err=%b, required %0d 1 0", name, move_count, busy, err, exp_c);
            end
            n_chk++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL %s_missing: got %0d moves left, required 0", name, exp_q.size());
            end
            if (exp_lat >= 0) begin
                n_chk++;
                if (n - t_done != exp_lat) begin
                    n_err++;
                    $display("FAIL %s_latency: got %0d, required %0d", name, n - t_done, exp_lat);
                end
            end
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || list_done !== 1'b0 || ld_count - ld0 != 1) begin
                n_err++;
                $display("FAIL %s_after: got busy=%b ld=%b pulses=%0d, required 0 0 1", name, busy, list_done, ld_count - ld0);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (sq_reset !== 1'b1 || sq_rden !== '0 || mv_valid !== 1'b0 || mv_data !== '0 ||
            busy !== 1'b0 || list_done !== 1'b0 || err !== 1'b0 || move_count !== 8'd0 || sq_sel !== 6'd0) begin
            n_err++;
            $display("FAIL reset_vals: got sq_reset=%b rden=%h v=%b d=%h busy=%b ld=%b err=%b cnt=%0d, required 1 0 0 0 0 0 0 0",
                     sq_reset, sq_rden, mv_valid, mv_data, busy, list_done, err, move_count);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (sq_reset !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got sq_reset=%b busy=%b, required 0 0", sq_reset, busy);
        end
    endtask

    task automatic test_empty();
        clear_cfg();
        rdy_mode = 0;
        run_pass("empty", 67);
    endtask

    task automatic test_single();
        logic [159:0] w;
        int b12;
        clear_cfg();
        w = mkword(8'h00);
        w[19*7 +: 19] = 19'h00A3C;
        w[19*2 +: 19] = 19'h10F9E;
        pend[12].push_back(w);
        rdy_mode = 0;
        b12 = rden_cnt[12];
        run_pass("single", 78);
        n_chk++;
        if (rden_cnt[12] - b12 != 1 || move_count !== 8'd2) begin
            n_err++;
            $display("FAIL single_rden: got reads=%0d cnt=%0d, required 1 2", rden_cnt[12] - b12, move_count);
        end
    endtask

    task automatic test_backpressure();
        int b0, b63;
        clear_cfg();
        for (int j = 0; j < 2; j++) begin
            pend[0].push_back(mkword(8'hFF));
            pend[63].push_back(mkword(8'hFF));
        end
        rdy_mode = 1;
        b0 = rden_cnt[0]; b63 = rden_cnt[63];
        run_pass("backpressure", -1);
        n_chk++;
        if (move_count !== 8'd32 || rden_cnt[0] - b0 != 2 || rden_cnt[63] - b63 != 2) begin
            n_err++;
            $display("FAIL bp_counts: got cnt=%0d r0=%0d r63=%0d, required 32 2 2", move_count, rden_cnt[0] - b0, rden_cnt[63] - b63);
        end
    endtask

    task automatic test_watchdog();
        int n, ld0;
        bit got;
        clear_cfg();
        done_mask = 64'hFFFF_FFFF_FFFF_FFFE;
        rdy_mode = 0;
        ld0 = ld_count;
        do_start();
        got = 0;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 100) start = 1'b1;
            if (n == 101) start = 1'b0;
            if (list_done) begin got = 1; break; end
        end
        n_chk++;
        if (!got || n != 257 || err !== 1'b1 || busy !== 1'b1 || move_count !== 8'd0) begin
            n_err++;
            $display("FAIL wd_fire: got seen=%b at=%0d err=%b busy=%b cnt=%0d, required 1 257 1 1 0", got, n, err, busy, move_count);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (err !== 1'b1 || busy !== 1'b0 || list_done !== 1'b0 || ld_count - ld0 != 1) begin
            n_err++;
            $display("FAIL wd_sticky: got err=%b busy=%b ld=%b pulses=%0d, required 1 0 0 1", err, busy, list_done, ld_count - ld0);
        end
    endtask

    task automatic test_random();
        int base [NSQ];
        int bad, s;
        for (int it = 0; it < 3; it++) begin
            clear_cfg();
            for (int j = 0; j < $urandom_range(1, 6); j++) begin
                s = $urandom_range(0, NSQ - 1);
                for (int w = 0; w < $urandom_range(1, 3); w++) pend[s].push_back(mkword(8'($urandom)));
            end
            for (int i = 0; i < NSQ; i++) base[i] = rden_cnt[i];
            rdy_mode = 2;
            run_pass("random", -1);
            bad = 0;
            for (int i = 0; i < NSQ; i++) if (rden_cnt[i] - base[i] != pend[i].size()) bad++;
            n_chk++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL random_reads: got %0d squares with wrong read count, required 0", bad);
            end
        end
    endtask

    task automatic test_saturate();
        clear_cfg();
        for (int i = 0; i < 17; i++) begin
            pend[i * 3].push_back(mkword(8'hFF));
            pend[i * 3].push_back(mkword(8'hFF));
        end
        rdy_mode = 0;
        run_pass("saturate", 67 + 34 * 11);
    endtask

    task automatic test_reset_mid();
        int n, ld0;
        bit got;
        clear_cfg();
        pend[5].push_back(mkword(8'hFF));
        pend[5].push_back(mkword(8'hFF));
        build_exp();
        rdy_mode = 1;
        do_start();
        got = 0;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (mv_valid && move_count >= 8'd3) begin got = 1; break; end
        end
        n_chk++;
        if (!got) begin
            n_err++;
            $display("FAIL mid_reach: got no UNPK with 3 moves, required it within 600 cycles");
        end
        reset_n = 1'b0;
        ld0 = ld_count;
        @(negedge clk);
        n_chk++;
        if (mv_valid !== 1'b0 || busy !== 1'b0 || list_done !== 1'b0 || sq_reset !== 1'b1) begin
            n_err++;
            $display("FAIL mid_abort: got v=%b busy=%b ld=%b sq_reset=%b, required 0 0 0 1", mv_valid, busy, list_done, sq_reset);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        n_chk++;
        if (ld_count != ld0 || move_count !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_quiet: got pulses=%0d cnt=%0d busy=%b, required 0 0 0", ld_count - ld0, move_count, busy);
        end
        clear_cfg();
        pend[40].push_back(mkword(8'hA5));
        rdy_mode = 0;
        run_pass("post_reset", 78);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_backpressure();
        test_watchdog();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
